// File: rtl/easyaxi_ar_arb_pkg.sv
// ---------------------------------------------------------------------------
// easyaxi_ar_arb_pkg
// Shared AXI sizing constants for the EasyAXI top level and the state
// encoding used by the AR-channel arbiter.
//   AXI_ID_WIDTH   : per-master ARID width
//   AXI_ADDR_WIDTH : ARADDR width
//   AXI_MST_NUM    : number of masters sharing the AR channel
// ---------------------------------------------------------------------------
package easyaxi_ar_arb_pkg;

   localparam int AXI_ID_WIDTH   = 4;
   localparam int AXI_ADDR_WIDTH = 32;
   localparam int AXI_MST_NUM    = 4;

   // IDLE: output register empty; BUSY: output register holds a request
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_t;

endpackage : easyaxi_ar_arb_pkg

// File: rtl/easyaxi_ar_arb_rr.sv
// ---------------------------------------------------------------------------
// easyaxi_rr_arb
// Combinational round-robin pick. Scans the request vector starting at
// i_ptr, wrapping past N-1 to 0, and reports the first requester.
// Shared between the AR and AW channel arbiters.
//   i_req   : request vector
//   i_ptr   : highest-priority index this cycle
//   o_grant : one-hot grant (zero when no request)
//   o_idx   : binary index of the winner (0 when no request)
//   o_any   : at least one request present
// ---------------------------------------------------------------------------
module easyaxi_rr_arb #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_grant,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   logic [IW-1:0] w_cand;

   // Walk offsets from farthest to nearest so the nearest requester to
   // i_ptr is the last assignment and therefore the winner.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = |i_req;
      w_cand  = '0;
      for (int k = N - 1; k >= 0; k--) begin
         w_cand = IW'((int'(i_ptr) + k) % N);
         if (i_req[w_cand]) begin
            o_grant         = '0;
            o_grant[w_cand] = 1'b1;
            o_idx           = w_cand;
         end
      end
   end

endmodule : easyaxi_rr_arb

// File: rtl/easyaxi_ar_arb.sv
// ---------------------------------------------------------------------------
// easyaxi_ar_arb
// Round-robin arbiter sharing one AXI read-address channel between MST_NUM
// masters and a single slave. Granted requests pass through one output
// register; the master index is prefixed onto ARID for R-channel routing.
//   clk, rst          : clock, asynchronous active-high reset
//   enable            : permits new grants
//   axi_mst_arvalid   : per-master request
//   axi_mst_arready   : per-master accept (one-hot or zero)
//   axi_mst_arid      : packed per-master ARIDs
//   axi_mst_araddr    : packed per-master ARADDRs
//   axi_slv_arvalid   : downstream valid (registered)
//   axi_slv_arready   : downstream ready
//   axi_slv_arid      : {master index, ARID} (registered)
//   axi_slv_araddr    : downstream address (registered)
// ---------------------------------------------------------------------------
module easyaxi_ar_arb
   import easyaxi_ar_arb_pkg::*;
#(
   parameter int MST_NUM    = AXI_MST_NUM,
   parameter int ID_WIDTH   = AXI_ID_WIDTH,
   parameter int ADDR_WIDTH = AXI_ADDR_WIDTH
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            enable,
   input  logic [MST_NUM-1:0]              axi_mst_arvalid,
   output logic [MST_NUM-1:0]              axi_mst_arready,
   input  logic [MST_NUM*ID_WIDTH-1:0]     axi_mst_arid,
   input  logic [MST_NUM*ADDR_WIDTH-1:0]   axi_mst_araddr,
   output logic                            axi_slv_arvalid,
   input  logic                            axi_slv_arready,
   output logic [$clog2(MST_NUM)+ID_WIDTH-1:0] axi_slv_arid,
   output logic [ADDR_WIDTH-1:0]           axi_slv_araddr
);

   localparam int IDX_WIDTH = $clog2(MST_NUM);

   arb_state_t             r_state;
   arb_state_t             w_state_next;
   logic [IDX_WIDTH-1:0]   r_rr_ptr;
   logic [IDX_WIDTH+ID_WIDTH-1:0] r_arid;
   logic [ADDR_WIDTH-1:0]  r_araddr;

   logic [MST_NUM-1:0]     w_grant;
   logic [IDX_WIDTH-1:0]   w_idx;
   logic                   w_any;
   logic                   w_take;

   logic [ID_WIDTH-1:0]    w_mst_id   [MST_NUM];
   logic [ADDR_WIDTH-1:0]  w_mst_addr [MST_NUM];

   // Unpack the flat master buses so the winner can be picked by index
   generate
      for (genvar gi = 0; gi < MST_NUM; gi++) begin : g_unpack
         assign w_mst_id[gi]   = axi_mst_arid[gi*ID_WIDTH +: ID_WIDTH];
         assign w_mst_addr[gi] = axi_mst_araddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      end
   endgenerate

   easyaxi_rr_arb #(
      .N  (MST_NUM),
      .IW (IDX_WIDTH)
   ) u_rr_arb (
      .i_req   (axi_mst_arvalid),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   // A new request is accepted when the output register is empty or is
   // being emptied this cycle; rst gates it so no master sees ready while
   // the arbiter is held in reset.
   assign w_take = ~rst & enable & w_any &
                   ((r_state == ST_IDLE) | axi_slv_arready);

   assign axi_mst_arready = w_take ? w_grant : '0;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (w_take) w_state_next = ST_BUSY;
         ST_BUSY: begin
            if (w_take)               w_state_next = ST_BUSY;
            else if (axi_slv_arready) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_rr_ptr <= '0;
         r_arid   <= '0;
         r_araddr <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_take) begin
            r_arid   <= {w_idx, w_mst_id[w_idx]};
            r_araddr <= w_mst_addr[w_idx];
            // Winner drops to lowest priority for the next pick
            if (w_idx == IDX_WIDTH'(MST_NUM - 1))
               r_rr_ptr <= '0;
            else
               r_rr_ptr <= w_idx + 1'b1;
         end
      end
   end

   assign axi_slv_arvalid = (r_state == ST_BUSY);
   assign axi_slv_arid    = r_arid;
   assign axi_slv_araddr  = r_araddr;

endmodule : easyaxi_ar_arb

// File: tb/tb_easyaxi_ar_arb.sv
module tb_easyaxi_ar_arb;

   localparam int N  = 4;
   localparam int IW = 4;
   localparam int AW = 32;
   localparam int XW = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              enable;
   logic [N-1:0]      mst_arvalid;
   logic [N-1:0]      mst_arready;
   logic [N*IW-1:0]   mst_arid;
   logic [N*AW-1:0]   mst_araddr;
   logic              slv_arvalid;
   logic              slv_arready;
   logic [XW+IW-1:0]  slv_arid;
   logic [AW-1:0]     slv_araddr;

   int n_total = 0;
   int n_pass  = 0;

   easyaxi_ar_arb #(.MST_NUM(N), .ID_WIDTH(IW), .ADDR_WIDTH(AW)) dut (
      .clk             (clk),
      .rst             (rst),
      .enable          (enable),
      .axi_mst_arvalid (mst_arvalid),
      .axi_mst_arready (mst_arready),
      .axi_mst_arid    (mst_arid),
      .axi_mst_araddr  (mst_araddr),
      .axi_slv_arvalid (slv_arvalid),
      .axi_slv_arready (slv_arready),
      .axi_slv_arid    (slv_arid),
      .axi_slv_araddr  (slv_araddr)
   );

   always #5 clk = ~clk;

   // advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_payload(input int m, input logic [IW-1:0] id, input logic [AW-1:0] addr);
      mst_arid[m*IW +: IW]   = id;
      mst_araddr[m*AW +: AW] = addr;
   endtask

   task automatic default_payloads();
      for (int m = 0; m < N; m++) set_payload(m, IW'(m + 4), 32'h1000 + 32'(m * 16));
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b1; slv_arready = 1'b1;
      mst_arvalid = 4'b1111;
      default_payloads();
      #3;
      n_total++;
      if (mst_arready !== 4'b0000) $display("FAIL reset_arready got=%b exp=0000", mst_arready); else n_pass++;
      n_total++;
      if (slv_arvalid !== 1'b0) $display("FAIL reset_arvalid got=%b exp=0", slv_arvalid); else n_pass++;
      n_total++;
      if (slv_arid !== '0 || slv_araddr !== '0)
         $display("FAIL reset_payload got id=%h addr=%h exp 0/0", slv_arid, slv_araddr);
      else n_pass++;
      mst_arvalid = '0;
      tick();
      rst = 1'b0;
      tick();
      $display("reset: done");
   endtask

   task automatic test_single();
      set_payload(2, 4'h3, 32'h100);
      mst_arvalid = 4'b0100; slv_arready = 1'b1;
      #1;
      n_total++;
      if (mst_arready !== 4'b0100) $display("FAIL single_arready got=%b exp=0100", mst_arready); else n_pass++;
      tick();
      mst_arvalid = '0;
      #1;
      n_total++;
      if (slv_arvalid !== 1'b1 || slv_arid !== 6'h23 || slv_araddr !== 32'h100)
         $display("FAIL single_out got v=%b id=%h addr=%h exp v=1 id=23 addr=100", slv_arvalid, slv_arid, slv_araddr);
      else n_pass++;
      n_total++;
      if (mst_arready !== 4'b0000) $display("FAIL single_noreq got=%b exp=0000", mst_arready); else n_pass++;
      tick();
      n_total++;
      if (slv_arvalid !== 1'b0) $display("FAIL single_drain got=%b exp=0", slv_arvalid); else n_pass++;
      $display("single: grant m2 id=%h addr=%h", 6'h23, 32'h100);
   endtask

   task automatic test_round_robin();
      int order [6] = '{0, 1, 2, 3, 0, 1};
      default_payloads();
      // pointer sits at 3; a lone request from master 3 is taken and moves it to 0
      mst_arvalid = 4'b1000; slv_arready = 1'b1;
      #1;
      n_total++;
      if (mst_arready !== 4'b1000) $display("FAIL rr_lone3 got=%b exp=1000", mst_arready); else n_pass++;
      tick();
      mst_arvalid = 4'b1111;
      for (int k = 0; k < 6; k++) begin
         logic [N-1:0] exp_rdy;
         exp_rdy = '0;
         exp_rdy[order[k]] = 1'b1;
         #1;
         n_total++;
         if (mst_arready !== exp_rdy) $display("FAIL rr_grant%0d got=%b exp=%b", k, mst_arready, exp_rdy); else n_pass++;
         tick();
         n_total++;
         if (slv_arvalid !== 1'b1 || slv_arid !== {2'(order[k]), 4'(order[k] + 4)} ||
             slv_araddr !== 32'h1000 + 32'(order[k] * 16))
            $display("FAIL rr_beat%0d got v=%b id=%h addr=%h exp master %0d", k, slv_arvalid, slv_arid, slv_araddr, order[k]);
         else n_pass++;
         $display("round_robin: beat %0d master %0d", k, order[k]);
      end
      mst_arvalid = '0;
      tick();
   endtask

   task automatic test_backpressure();
      // pointer at 2; lone master 1 granted, pointer back to 2
      mst_arvalid = 4'b0010; slv_arready = 1'b1;
      tick();
      mst_arvalid = 4'b0110; slv_arready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         n_total++;
         if (mst_arready !== 4'b0000 || slv_arvalid !== 1'b1 || slv_arid !== 6'h15 || slv_araddr !== 32'h1010)
            $display("FAIL bp_stall%0d got rdy=%b v=%b id=%h addr=%h exp rdy=0000 v=1 id=15 addr=1010",
                     k, mst_arready, slv_arvalid, slv_arid, slv_araddr);
         else n_pass++;
         tick();
      end
      slv_arready = 1'b1;
      #1;
      n_total++;
      if (mst_arready !== 4'b0100) $display("FAIL bp_release got=%b exp=0100", mst_arready); else n_pass++;
      tick();
      mst_arvalid = '0;
      n_total++;
      if (slv_arvalid !== 1'b1 || slv_arid !== 6'h26) $display("FAIL bp_next got v=%b id=%h exp v=1 id=26", slv_arvalid, slv_arid); else n_pass++;
      tick();
      $display("backpressure: m1 held 5 cycles, then m2");
   endtask

   task automatic test_withdrawn();
      // pointer at 3; lone master 0 granted, pointer to 1
      mst_arvalid = 4'b0001; slv_arready = 1'b1;
      tick();
      mst_arvalid = 4'b0010; slv_arready = 1'b0;
      #1;
      n_total++;
      if (mst_arready !== 4'b0000) $display("FAIL wd_stall got=%b exp=0000", mst_arready); else n_pass++;
      tick();
      mst_arvalid = '0; slv_arready = 1'b1;
      #1;
      n_total++;
      if (mst_arready !== 4'b0000) $display("FAIL wd_dropped got=%b exp=0000", mst_arready); else n_pass++;
      tick();
      // pointer must still be 1, so master 1 wins a full request set
      mst_arvalid = 4'b1111;
      #1;
      n_total++;
      if (mst_arready !== 4'b0010) $display("FAIL wd_ptr got=%b exp=0010", mst_arready); else n_pass++;
      tick();
      mst_arvalid = '0;
      tick();
      $display("withdrawn: m1 skipped, pointer kept");
   endtask

   task automatic test_enable();
      // pointer at 2; masters 0,3 -> 3 wins, pointer to 0
      mst_arvalid = 4'b1001; slv_arready = 1'b1; enable = 1'b1;
      #1;
      n_total++;
      if (mst_arready !== 4'b1000) $display("FAIL en_first got=%b exp=1000", mst_arready); else n_pass++;
      tick();
      enable = 1'b0;
      #1;
      n_total++;
      if (mst_arready !== 4'b0000 || slv_arvalid !== 1'b1 || slv_arid !== 6'h37)
         $display("FAIL en_low_busy got rdy=%b v=%b id=%h exp rdy=0000 v=1 id=37", mst_arready, slv_arvalid, slv_arid);
      else n_pass++;
      tick();
      n_total++;
      if (slv_arvalid !== 1'b0 || mst_arready !== 4'b0000)
         $display("FAIL en_low_idle got v=%b rdy=%b exp v=0 rdy=0000", slv_arvalid, mst_arready);
      else n_pass++;
      tick();
      enable = 1'b1;
      #1;
      n_total++;
      if (mst_arready !== 4'b0001) $display("FAIL en_resume got=%b exp=0001", mst_arready); else n_pass++;
      tick();
      mst_arvalid = '0;
      n_total++;
      if (slv_arid !== 6'h04) $display("FAIL en_resume_id got=%h exp=04", slv_arid); else n_pass++;
      tick();
      $display("enable: pending completed, resumed at m0");
   endtask

   task automatic test_async_reset();
      // pointer at 1; lone master 0 with araddr 0x40
      set_payload(0, 4'h4, 32'h40);
      mst_arvalid = 4'b0001; slv_arready = 1'b1;
      tick();
      mst_arvalid = '0; slv_arready = 1'b0;
      #1;
      n_total++;
      if (slv_arvalid !== 1'b1 || slv_araddr !== 32'h40) $display("FAIL ar_busy got v=%b addr=%h exp v=1 addr=40", slv_arvalid, slv_araddr); else n_pass++;
      #1;
      rst = 1'b1;
      mst_arvalid = 4'b1111;
      #1;
      n_total++;
      if (slv_arvalid !== 1'b0 || slv_arid !== '0 || slv_araddr !== '0 || mst_arready !== 4'b0000)
         $display("FAIL ar_clear got v=%b id=%h addr=%h rdy=%b exp all 0", slv_arvalid, slv_arid, slv_araddr, mst_arready);
      else n_pass++;
      tick();
      rst = 1'b0;
      slv_arready = 1'b1;
      #1;
      n_total++;
      if (mst_arready !== 4'b0001) $display("FAIL ar_ptr got=%b exp=0001", mst_arready); else n_pass++;
      tick();
      mst_arvalid = '0;
      tick();
      $display("async_reset: cleared mid-busy");
   endtask

   initial begin
      mst_arid = '0; mst_araddr = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_withdrawn();
      test_enable();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_easyaxi_ar_arb
